// File: rtl/led_breathe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : led_breathe                                                 |
// | Purpose  : Four-channel LED breathing driver. A free-running PWM is    |
// |            modulated by a triangle duty ramp with top/bottom plateaus. |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module led_breathe #(
  parameter int PWM_WIDTH   = 8,
  parameter int DIV_PERIODS = 64,
  parameter int HOLD_STEPS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_mode,
  output logic [3:0]           o_led,
  output logic [PWM_WIDTH-1:0] o_duty,
  output logic [1:0]           o_state,
  output logic                 o_step
);

  localparam int c_DIV_W  = (DIV_PERIODS > 1) ? $clog2(DIV_PERIODS) : 1;
  localparam int c_HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PWM_WIDTH-1:0] c_MAX       = {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] c_PWM_ONE   = PWM_WIDTH'(1);
  localparam logic [PWM_WIDTH-1:0] c_PWM_ZERO  = '0;
  localparam logic [c_DIV_W-1:0]   c_DIV_LAST  = c_DIV_W'(DIV_PERIODS - 1);
  localparam logic [c_DIV_W-1:0]   c_DIV_ONE   = c_DIV_W'(1);
  // With no plateau the hold states are unreachable; keep the constant legal.
  localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam logic [c_HOLD_W-1:0]  c_HOLD_ONE  = c_HOLD_W'(1);

  typedef enum logic [1:0] {
    S_UP       = 2'd0,
    S_HOLD_TOP = 2'd1,
    S_DOWN     = 2'd2,
    S_HOLD_BOT = 2'd3
  } state_t;

  // Registered state
  logic [PWM_WIDTH-1:0] r_pwm_cnt;
  logic [c_DIV_W-1:0]   r_div_cnt;
  logic [c_HOLD_W-1:0]  r_hold_cnt;
  logic [PWM_WIDTH-1:0] r_duty;
  state_t               r_state;
  logic                 r_mode_q;
  logic [3:0]           r_led;
  logic                 r_step;

  // Combinational
  logic                 w_wrap;
  logic                 w_strobe;
  state_t               w_state_nxt;
  logic [PWM_WIDTH-1:0] w_duty_nxt;
  logic [c_HOLD_W-1:0]  w_hold_nxt;
  logic [PWM_WIDTH-1:0] w_duty_ch [4];
  logic [3:0]           w_led_nxt;

  // Last count of a PWM period; duty and mode may only change on this edge.
  assign w_wrap   = (r_pwm_cnt == c_MAX);
  assign w_strobe = w_wrap && (r_div_cnt == c_DIV_LAST);

  // Per-channel duty and PWM compare (graded brightness in mode 1)
  for (genvar k = 0; k < 4; k++) begin : g_ch
    assign w_duty_ch[k] = r_mode_q ? (r_duty >> k) : r_duty;
    assign w_led_nxt[k] = (r_pwm_cnt < w_duty_ch[k]);
  end

  // Next-state, next-duty and plateau counter, evaluated only on a fade step
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_hold_nxt  = r_hold_cnt;
    if (w_strobe) begin
      case (r_state)
        S_UP: begin
          w_duty_nxt = r_duty + c_PWM_ONE;
          if (w_duty_nxt == c_MAX) begin
            w_state_nxt = (HOLD_STEPS == 0) ? S_DOWN : S_HOLD_TOP;
          end
        end
        S_HOLD_TOP: begin
          if (r_hold_cnt == c_HOLD_LAST) begin
            w_hold_nxt  = '0;
            w_state_nxt = S_DOWN;
          end else begin
            w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
          end
        end
        S_DOWN: begin
          w_duty_nxt = r_duty - c_PWM_ONE;
          if (w_duty_nxt == c_PWM_ZERO) begin
            w_state_nxt = (HOLD_STEPS == 0) ? S_UP : S_HOLD_BOT;
          end
        end
        S_HOLD_BOT: begin
          if (r_hold_cnt == c_HOLD_LAST) begin
            w_hold_nxt  = '0;
            w_state_nxt = S_UP;
          end else begin
            w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
          end
        end
        default: w_state_nxt = S_UP;
      endcase
    end
  end

  // FSM state register with duty and plateau counter; disable clears synchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_UP;
      r_duty     <= '0;
      r_hold_cnt <= '0;
    end else if (!i_en) begin
      r_state    <= S_UP;
      r_duty     <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_duty     <= w_duty_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // PWM and divider counters, mode sampling at period start, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_div_cnt <= '0;
      r_mode_q  <= 1'b0;
      r_led     <= '0;
      r_step    <= 1'b0;
    end else if (!i_en) begin
      r_pwm_cnt <= '0;
      r_div_cnt <= '0;
      r_mode_q  <= 1'b0;
      r_led     <= '0;
      r_step    <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + c_PWM_ONE;
      if (w_wrap) begin
        r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_ONE;
        r_mode_q  <= i_mode;
      end
      r_led  <= w_led_nxt;
      r_step <= w_strobe;
    end
  end

  assign o_led   = r_led;
  assign o_duty  = r_duty;
  assign o_state = r_state;
  assign o_step  = r_step;

endmodule
`default_nettype wire
